// File: rtl/uart_rx_module.sv
// uart_rx_module -- 8N1 UART receiver with OVS-times oversampling and
// mid-bit sampling.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rx_in      serial line (asynchronous to clk, idle high)
//   rx_data    last correctly received byte (held until the next good frame)
//   rx_valid   one-cycle pulse, rx_data updated with a good frame
//   rx_busy    high from confirmed start bit until mid-stop
//   frame_err  one-cycle pulse, stop bit sampled low (rx_data unchanged)
//   ovs_tick   one-cycle oversample strobe
module uart_rx_module #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600,
  parameter int OVS      = 16,
  parameter int OVS_DIV  = CLK_FREQ / (BAUD * OVS)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       ovs_tick
);

  localparam int DIV_W  = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
  localparam int TICK_W = $clog2(OVS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                ovs_tick_q, ovs_tick_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [7:0]          shift_q, shift_d;
  logic [7:0]          rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic                rx_busy_q, rx_busy_d;
  logic                frame_err_q, frame_err_d;
  logic                armed_q, armed_d;
  logic                rx_s;

  assign rx_s = sync2_q;

  always_comb begin
    sync1_d     = rx_in;
    sync2_d     = sync1_q;

    // Free-running divider; the strobe is registered, so the FSM sees it
    // one cycle after the wrap, which only shifts every sample uniformly.
    if (div_cnt_q == DIV_W'(OVS_DIV - 1)) begin
      div_cnt_d  = '0;
      ovs_tick_d = 1'b1;
    end else begin
      div_cnt_d  = div_cnt_q + 1'b1;
      ovs_tick_d = 1'b0;
    end

    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    rx_busy_d   = rx_busy_q;
    frame_err_d = 1'b0;
    armed_d     = armed_q;

    unique case (state_q)
      S_IDLE: begin
        // Start detection requires having seen the line high first, so a
        // line held low after a framing error cannot retrigger.
        if (armed_q && !rx_s) begin
          state_d    = S_START;
          tick_cnt_d = '0;
          armed_d    = 1'b0;
        end else if (rx_s) begin
          armed_d = 1'b1;
        end
      end

      S_START: begin
        if (ovs_tick_q) begin
          if (tick_cnt_q == TICK_W'(OVS / 2 - 1)) begin
            if (!rx_s) begin
              state_d    = S_DATA;
              rx_busy_d  = 1'b1;
              tick_cnt_d = '0;
              bit_idx_d  = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (ovs_tick_q) begin
          if (tick_cnt_q == TICK_W'(OVS - 1)) begin
            shift_d[bit_idx_q] = rx_s;
            tick_cnt_d         = '0;
            if (bit_idx_q == 3'd7) begin
              state_d = S_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      S_STOP: begin
        if (ovs_tick_q) begin
          if (tick_cnt_q == TICK_W'(OVS - 1)) begin
            // Leaving at mid-stop gives half a bit to re-arm before a
            // back-to-back start edge.
            state_d    = S_IDLE;
            tick_cnt_d = '0;
            rx_busy_d  = 1'b0;
            if (rx_s) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      div_cnt_q   <= '0;
      ovs_tick_q  <= 1'b0;
      tick_cnt_q  <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_busy_q   <= 1'b0;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      div_cnt_q   <= div_cnt_d;
      ovs_tick_q  <= ovs_tick_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_busy_q   <= rx_busy_d;
      frame_err_q <= frame_err_d;
      armed_q     <= armed_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_busy   = rx_busy_q;
  assign frame_err = frame_err_q;
  assign ovs_tick  = ovs_tick_q;

endmodule

// File: tb/tb_uart_rx_module.sv
// Testbench for uart_rx_module: scaled-down baud (16 clk per bit, OVS=8,
// OVS_DIV=2) so that the 256-value sweep stays short.
module tb_uart_rx_module;

  localparam int P_CLK   = 160000;
  localparam int P_BAUD  = 10000;
  localparam int P_OVS   = 8;
  localparam int P_DIV   = P_CLK / (P_BAUD * P_OVS);
  localparam int BIT_CLK = P_OVS * P_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       ovs_tick;

  int         vectors = 0;
  int         miscompares = 0;
  logic [8:0] exp_q[$];          // bit 8 = expect frame_err, [7:0] = rx_data
  logic [7:0] last_good = 8'h00;
  bit         seen[256];
  int         busy_cycles = 0;
  bit         busy_count_en = 1'b0;

  uart_rx_module #(
    .CLK_FREQ(P_CLK),
    .BAUD    (P_BAUD),
    .OVS     (P_OVS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_in    (rx_in),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_busy  (rx_busy),
    .frame_err(frame_err),
    .ovs_tick (ovs_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Output monitor: pops the scoreboard on every rx_valid / frame_err pulse.
  always @(negedge clk) begin
    logic [8:0] e;
    if (busy_count_en && rx_busy) busy_cycles++;
    if (rx_valid || frame_err) begin
      vectors++;
      if (rx_valid && frame_err) begin
        miscompares++;
        $display("FAIL both_flags: got valid=1 ferr=1, required only one");
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: got valid=%0b ferr=%0b data=%h, required no pulse",
                 rx_valid, frame_err, rx_data);
      end else begin
        e = exp_q.pop_front();
        if ({frame_err, rx_data} !== e) begin
          miscompares++;
          $display("FAIL frame: got ferr=%0b data=%h, required ferr=%0b data=%h",
                   frame_err, rx_data, e[8], e[7:0]);
        end else if (rx_valid) begin
          seen[rx_data] = 1'b1;
        end
      end
    end
  end

  task automatic drive_line(input logic v, input int n);
    rx_in = v;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      exp_q.push_back({1'b0, b});
      last_good = b;
    end else begin
      exp_q.push_back({1'b1, last_good});
    end
    drive_line(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive_line(b[i], BIT_CLK);
    drive_line(stop, BIT_CLK);
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(posedge clk);
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: got %0d frames outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    int ticks = 0;
    rst = 1'b0;
    rx_in = 1'b1;
    repeat (5) @(negedge clk);
    vectors++;
    if ({rx_data, rx_valid, rx_busy, frame_err, ovs_tick} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs: got data=%h v=%0b b=%0b fe=%0b t=%0b, required all 0",
               rx_data, rx_valid, rx_busy, frame_err, ovs_tick);
    end
    rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (ovs_tick) ticks++;
    end
    vectors++;
    if (ticks != 40 / P_DIV) begin
      miscompares++;
      $display("FAIL ovs_tick_rate: got %0d ticks, required %0d", ticks, 40 / P_DIV);
    end
    drive_line(1'b1, 2 * BIT_CLK);
  endtask

  task automatic test_single();
    busy_cycles = 0;
    busy_count_en = 1'b1;
    send_frame(8'h4D, 1'b1);
    wait_drain(4 * BIT_CLK);
    busy_count_en = 1'b0;
    vectors++;
    if (busy_cycles != 9 * BIT_CLK) begin
      miscompares++;
      $display("FAIL busy_width: got %0d cycles, required %0d", busy_cycles, 9 * BIT_CLK);
    end
    drive_line(1'b1, BIT_CLK);
  endtask

  task automatic test_back_to_back();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'hAA, 1'b1);
    wait_drain(4 * BIT_CLK);
    vectors++;
    if (rx_data !== 8'hAA) begin
      miscompares++;
      $display("FAIL b2b_hold: got %h, required aa", rx_data);
    end
    drive_line(1'b1, BIT_CLK);
  endtask

  task automatic test_glitch();
    bit busy_seen = 1'b0;
    drive_line(1'b0, 3);
    rx_in = 1'b1;
    repeat (3 * BIT_CLK) begin
      @(negedge clk);
      if (rx_busy) busy_seen = 1'b1;
    end
    vectors++;
    if (busy_seen) begin
      miscompares++;
      $display("FAIL glitch_busy: got busy=1, required 0");
    end
    send_frame(8'h55, 1'b1);
    wait_drain(4 * BIT_CLK);
    drive_line(1'b1, BIT_CLK);
  endtask

  task automatic test_framing();
    bit busy_seen = 1'b0;
    send_frame(8'h3C, 1'b0);
    rx_in = 1'b0;
    repeat (3 * BIT_CLK) begin
      @(negedge clk);
      if (rx_busy) busy_seen = 1'b1;
    end
    vectors++;
    if (busy_seen) begin
      miscompares++;
      $display("FAIL stuck_low_retrigger: got busy=1, required 0");
    end
    wait_drain(BIT_CLK);
    drive_line(1'b1, 2 * BIT_CLK);
    send_frame(8'h81, 1'b1);
    wait_drain(4 * BIT_CLK);
    drive_line(1'b1, BIT_CLK);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b = 8'hF0;
    drive_line(1'b0, BIT_CLK);
    for (int i = 0; i < 4; i++) drive_line(b[i], BIT_CLK);
    drive_line(b[4], BIT_CLK / 2);
    @(negedge clk);
    vectors++;
    if (rx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL midframe_busy: got %0b, required 1", rx_busy);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if ({rx_data, rx_valid, rx_busy, frame_err, ovs_tick} !== 12'h000) begin
      miscompares++;
      $display("FAIL async_reset: got data=%h v=%0b b=%0b fe=%0b t=%0b, required all 0",
               rx_data, rx_valid, rx_busy, frame_err, ovs_tick);
    end
    rx_in = 1'b1;
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    drive_line(1'b1, 2 * BIT_CLK);
    send_frame(8'h12, 1'b1);
    wait_drain(4 * BIT_CLK);
    drive_line(1'b1, BIT_CLK);
  endtask

  task automatic test_loopback();
    int hits = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    for (int v = 0; v < 256; v++) send_frame(8'(v), 1'b1);
    wait_drain(4 * BIT_CLK);
    foreach (seen[i]) if (seen[i]) hits++;
    vectors++;
    if (hits != 256) begin
      miscompares++;
      $display("FAIL loopback_coverage: got %0d values, required 256", hits);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_reset_midframe();
    test_loopback();
    repeat (2 * BIT_CLK) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
